// File: rtl/mac_dot_sequencer.sv
// Drives one mac_unit through an N-element signed dot product: clear, then fetch/issue/wait
// per operand pair, and return the accumulator with sticky overflow and timeout flags.
module mac_dot_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  output logic                     mac_reset,
  output logic                     mac_valid,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_y,
  input  logic                     mac_overflow,
  input  logic                     mac_done,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic signed [ACC_W-1:0]  resp_result,
  output logic                     resp_overflow,
  output logic                     resp_timeout
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic               ovf_q;
  logic               to_q;
  logic signed [ACC_W-1:0] result_q;
  logic               last_pair;
  logic               timer_expired;

  // The compare is done one bit wider so N = 2**LEN_W-1 cannot wrap.
  assign last_pair     = ({1'b0, cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q};
  assign timer_expired = (timer_q == TMR_LAST);

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    mac_valid = 1'b0;
    mac_reset = reset;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_len == '0) ? RESP : CLEAR;
      end
      CLEAR: begin
        mac_reset = 1'b1;
        state_d   = FETCH;
      end
      FETCH: begin
        op_ready = 1'b1;
        if (op_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mac_valid = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mac_done) state_d = last_pair ? RESP : FETCH;
        else if (timer_expired) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      result_q <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_valid) begin
          len_q    <= cmd_len;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
          to_q     <= 1'b0;
          result_q <= '0;
        end
        FETCH: if (op_valid) begin
          mac_a <= op_a;
          mac_b <= op_b;
        end
        ISSUE: timer_q <= '0;
        // A done arriving on the final timer cycle still counts as a normal completion.
        WAIT: if (mac_done) begin
          ovf_q <= ovf_q | mac_overflow;
          cnt_q <= cnt_q + LEN_W'(1);
          if (last_pair) result_q <= mac_y;
        end else if (timer_expired) begin
          to_q     <= 1'b1;
          result_q <= mac_y;
        end else begin
          timer_q <= timer_q + TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_result   = result_q;
  assign resp_overflow = ovf_q;
  assign resp_timeout  = to_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a wrapping-accumulator mac_unit model attached.
module tb_mac_dot_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;
  localparam int AMAX   = 2**(ACC_W-1) - 1;
  localparam int AMIN   = -(2**(ACC_W-1));

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [LEN_W-1:0]         cmd_len;
  logic                     op_valid;
  logic                     op_ready;
  logic signed [DATA_W-1:0] op_a, op_b;
  logic                     mac_reset, mac_valid;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]  mac_y;
  logic                     mac_overflow, mac_done;
  logic                     resp_valid, resp_ready;
  logic signed [ACC_W-1:0]  resp_result;
  logic                     resp_overflow, resp_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int nvalid  = 0;
  int nrst    = 0;
  logic done_en;
  int sum_c;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_reset(mac_reset), .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b),
    .mac_y(mac_y), .mac_overflow(mac_overflow), .mac_done(mac_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_timeout(resp_timeout)
  );

  // mac_unit model: wrapping accumulate, per-operation overflow, done one cycle after valid.
  always_comb sum_c = int'(mac_y) + int'(mac_a) * int'(mac_b);

  always @(posedge clk) begin
    if (mac_reset) begin
      mac_y        <= '0;
      mac_done     <= 1'b0;
      mac_overflow <= 1'b0;
    end else begin
      mac_done <= mac_valid & done_en;
      if (mac_valid) begin
        mac_y        <= sum_c[ACC_W-1:0];
        mac_overflow <= (sum_c > AMAX) || (sum_c < AMIN);
      end
    end
  end

  always @(posedge clk) begin
    if (mac_valid) nvalid <= nvalid + 1;
    if (mac_reset && !reset) nrst <= nrst + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int n);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(n);
    chk("cmd_ready_at_cmd", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int a, input int b);
    logic ok;
    ok = 1'b0;
    op_valid = 1'b1;
    op_a = DATA_W'(a);
    op_b = DATA_W'(b);
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = op_ready;
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("op_accepted", ok, 1);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("resp_valid_seen", resp_valid, 1);
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_dropped", resp_valid, 0);
    chk("cmd_ready_after_resp", cmd_ready, 1);
  endtask

  initial begin
    int v0, r0, cyc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; resp_ready = 1'b0; done_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_reset", mac_reset, 1);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_result", resp_result, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mac_reset", mac_reset, 0);

    // N=2: (30,40),(10,8) -> 1280, then 5 cycles of backpressure
    v0 = nvalid; r0 = nrst;
    send_cmd(2); feed(30, 40); feed(10, 8); wait_resp(cyc);
    chk("j1_result", resp_result, 1280);
    chk("j1_ovf", resp_overflow, 0);
    chk("j1_to", resp_timeout, 0);
    chk("j1_pulses", nvalid - v0, 2);
    chk("j1_clears", nrst - r0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 1280);
      chk("bp_flags", {resp_overflow, resp_timeout}, 0);
      chk("bp_op_ready", op_ready, 0);
    end
    accept();

    // N=2: (100,-2),(11,-11) -> -321
    send_cmd(2); feed(100, -2); feed(11, -11); wait_resp(cyc);
    chk("j2_result", resp_result, -321);
    chk("j2_ovf", resp_overflow, 0);
    accept();

    // N=4 of (127,127): overflow on the third add, sticky through the fourth
    v0 = nvalid;
    send_cmd(4);
    for (int i = 0; i < 4; i++) feed(127, 127);
    wait_resp(cyc);
    chk("j3_ovf", resp_overflow, 1);
    chk("j3_pulses", nvalid - v0, 4);
    chk("j3_result", resp_result, -1020);
    chk("j3_to", resp_timeout, 0);
    accept();

    // N=0: immediate zero response with no MAC activity
    v0 = nvalid; r0 = nrst;
    send_cmd(0);
    chk("n0_resp_valid", resp_valid, 1);
    chk("n0_result", resp_result, 0);
    chk("n0_flags", {resp_overflow, resp_timeout}, 0);
    chk("n0_pulses", nvalid - v0, 0);
    chk("n0_clears", nrst - r0, 0);
    accept();

    // mac_done stuck low, N=1 -> timeout after 16 WAIT cycles
    done_en = 1'b0; v0 = nvalid;
    send_cmd(1); feed(3, 4); wait_resp(cyc);
    chk("to_latency", cyc, 17);
    chk("to_flag", resp_timeout, 1);
    chk("to_result", resp_result, 12);
    chk("to_ovf", resp_overflow, 0);
    chk("to_pulses", nvalid - v0, 1);
    accept();

    // reset asserted while in WAIT aborts silently
    send_cmd(1); feed(5, 6);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_mac_reset", mac_reset, 1);
    chk("mid_mac_valid", mac_valid, 0);
    chk("mid_op_ready", op_ready, 0);
    chk("mid_flags", {resp_overflow, resp_timeout}, 0);
    reset = 1'b0; done_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_resp", resp_valid, 0);
    chk("mid_idle", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
